// File: rtl/seg_codes_pkg.sv
// Display codes and segment patterns shared by the
// seven-segment encoder and the readback scanner.
package seg_codes_pkg;

    localparam logic [4:0] CODE_OFF    = 5'd0;
    localparam logic [4:0] CODE_1      = 5'd1;
    localparam logic [4:0] CODE_2      = 5'd2;
    localparam logic [4:0] CODE_3      = 5'd3;
    localparam logic [4:0] CODE_4      = 5'd4;
    localparam logic [4:0] CODE_5      = 5'd5;
    localparam logic [4:0] CODE_6      = 5'd6;
    localparam logic [4:0] CODE_7      = 5'd7;
    localparam logic [4:0] CODE_8      = 5'd8;
    localparam logic [4:0] CODE_9      = 5'd9;
    localparam logic [4:0] CODE_STABLE = 5'd10;
    localparam logic [4:0] CODE_UP     = 5'd11;
    localparam logic [4:0] CODE_DOWN   = 5'd12;
    localparam logic [4:0] CODE_C      = 5'd13;
    localparam logic [4:0] CODE_L      = 5'd14;
    localparam logic [4:0] CODE_TIRE   = 5'd15;
    localparam logic [4:0] CODE_16     = 5'd16;
    localparam logic [4:0] CODE_ERR    = 5'd31;

    // Active-low, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG_OFF    = 7'b1111111;
    localparam logic [6:0] SEG_1      = 7'b1001111;
    localparam logic [6:0] SEG_2      = 7'b0010010;
    localparam logic [6:0] SEG_3      = 7'b0000110;
    localparam logic [6:0] SEG_4      = 7'b1001100;
    localparam logic [6:0] SEG_5      = 7'b0100100;
    localparam logic [6:0] SEG_6      = 7'b0100000;
    localparam logic [6:0] SEG_7      = 7'b0001111;
    localparam logic [6:0] SEG_8      = 7'b0000000;
    localparam logic [6:0] SEG_9      = 7'b0000100;
    localparam logic [6:0] SEG_STABLE = 7'b1111110;
    localparam logic [6:0] SEG_UP     = 7'b1000001;
    localparam logic [6:0] SEG_DOWN   = 7'b0001001;
    localparam logic [6:0] SEG_C      = 7'b0110001;
    localparam logic [6:0] SEG_L      = 7'b1110001;
    localparam logic [6:0] SEG_TIRE   = 7'b1111110;
    localparam logic [6:0] SEG_16     = 7'b1000010;

    typedef enum logic {
        ST_ACQUIRE,
        ST_LOCKED
    } scan_state_t;

endpackage

// File: rtl/segment_to_binary_scan_if.sv
// Bus between the segment scanner and its user:
// sampled panel lines in, recovered digit codes out.
interface segment_to_binary_scan_if;

    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        err_clr;
    logic [19:0] digits;
    logic [3:0]  digit_valid;
    logic        update;
    logic [1:0]  update_idx;
    logic        err;

    modport master (
        output an_n, seg_n, err_clr,
        input  digits, digit_valid, update, update_idx, err
    );

    modport slave (
        input  an_n, seg_n, err_clr,
        output digits, digit_valid, update, update_idx, err
    );

endinterface

// File: rtl/seg_pattern_decode.sv
// Maps a 7-bit active-low segment pattern back to its
// display code; unknown patterns yield CODE_ERR.
module seg_pattern_decode
    import seg_codes_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [4:0] code,
    output logic       illegal
);

    // SEG_TIRE shares its pattern with SEG_STABLE, so it decodes as STABLE.
    always_comb begin
        code = CODE_ERR;
        case (pattern)
            SEG_OFF:    code = CODE_OFF;
            SEG_1:      code = CODE_1;
            SEG_2:      code = CODE_2;
            SEG_3:      code = CODE_3;
            SEG_4:      code = CODE_4;
            SEG_5:      code = CODE_5;
            SEG_6:      code = CODE_6;
            SEG_7:      code = CODE_7;
            SEG_8:      code = CODE_8;
            SEG_9:      code = CODE_9;
            SEG_STABLE: code = CODE_STABLE;
            SEG_UP:     code = CODE_UP;
            SEG_DOWN:   code = CODE_DOWN;
            SEG_C:      code = CODE_C;
            SEG_L:      code = CODE_L;
            SEG_16:     code = CODE_16;
            default:    code = CODE_ERR;
        endcase
    end

    assign illegal = (code == CODE_ERR);

endmodule

// File: rtl/segment_to_binary_scan.sv
// Readback monitor for the multiplexed 4-digit display:
// debounces the anode/segment bus and recovers each digit code.
module segment_to_binary_scan
    import seg_codes_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter int SAMPLE_DIV = 1
)
(
    input  logic clk,
    input  logic rst_n,
    segment_to_binary_scan_if.slave bus
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [10:0]   sync1;
    logic [10:0]   sync2;
    logic [10:0]   cand;
    logic [10:0]   cpat;
    logic [CW-1:0] cnt;
    logic [DW-1:0] div;
    logic          tick;
    logic          diff;
    logic          commit_now;
    logic          commit_q;
    scan_state_t   state;

    logic [3:0]    an;
    logic [1:0]    idx;
    logic          one_hot;
    logic          multi;
    logic [4:0]    code;
    logic          illegal;
    logic [4:0]    cur;
    logic          err_set;

    logic [19:0]   digits_q;
    logic [3:0]    valid_q;
    logic          update_q;
    logic [1:0]    idx_q;
    logic          err_q;

    // Two-flop synchronizer; idles at all-ones like a blank panel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {bus.an_n, bus.seg_n};
            sync2 <= sync1;
        end
    end

    assign tick = (div == DW'(SAMPLE_DIV - 1));

    // Sample divider producing one tick every SAMPLE_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div <= '0;
        else if (tick)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    assign diff       = tick && (sync2 != cand);
    assign commit_now = (state == ST_ACQUIRE) &&
                        (cnt == CW'(STABLE_CNT));

    // Stability counter and acquire/lock FSM; commit is staged one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand     <= '1;
            cnt      <= '0;
            state    <= ST_ACQUIRE;
            commit_q <= 1'b0;
            cpat     <= '1;
        end else begin
            commit_q <= commit_now;
            if (commit_now)
                cpat <= cand;
            if (tick) begin
                if (sync2 != cand) begin
                    cand <= sync2;
                    cnt  <= CW'(1);
                end else if (cnt != CW'(STABLE_CNT)) begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (diff)
                state <= ST_ACQUIRE;
            else if (commit_now)
                state <= ST_LOCKED;
        end
    end

    assign an      = cpat[10:7];
    assign one_hot = $onehot(~an);
    assign multi   = !one_hot && (an != 4'b1111);

    // Lowest active anode selects the digit.
    always_comb begin
        idx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (!an[i])
                idx = 2'(i);
    end

    seg_pattern_decode u_decode (
        .pattern (cpat[6:0]),
        .code    (code),
        .illegal (illegal)
    );

    assign cur     = digits_q[int'(idx)*5 +: 5];
    assign err_set = commit_q && ((one_hot && illegal) || multi);

    // Digit registers, update pulse and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            valid_q  <= '0;
            update_q <= 1'b0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (commit_q && one_hot) begin
                digits_q[int'(idx)*5 +: 5] <= code;
                valid_q[idx] <= 1'b1;
                if (!valid_q[idx] || (cur != code)) begin
                    update_q <= 1'b1;
                    idx_q    <= idx;
                end
            end
            if (err_set)
                err_q <= 1'b1;
            else if (bus.err_clr)
                err_q <= 1'b0;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.update      = update_q;
    assign bus.update_idx  = idx_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_segment_to_binary_scan.sv
// Directed bench for segment_to_binary_scan: scan, latency,
// glitch rejection, error handling and mid-acquire reset.
module tb_segment_to_binary_scan;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    segment_to_binary_scan_if bus();

    segment_to_binary_scan #(
        .STABLE_CNT (3),
        .SAMPLE_DIV (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int pulses;
    int first_at;
    int tot;
    logic [1:0] last_idx;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive pins at a negedge, then watch n negedges for update pulses.
    task automatic drive(input logic [3:0] an,
                         input logic [6:0] seg,
                         input int n);
        bus.an_n  = an;
        bus.seg_n = seg;
        pulses   = 0;
        first_at = -1;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (bus.update) begin
                pulses++;
                last_idx = bus.update_idx;
                if (first_at < 0)
                    first_at = j;
            end
        end
    endtask

    task automatic clr_pulse();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
    endtask

    initial begin
        bus.an_n    = 4'b1111;
        bus.seg_n   = 7'b1111111;
        bus.err_clr = 1'b0;
        last_idx    = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_digits", 32'(bus.digits), 32'h0);
        check("rst_valid", 32'(bus.digit_valid), 32'h0);
        check("rst_update", 32'(bus.update), 32'h0);
        check("rst_idx", 32'(bus.update_idx), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Scan four digits: 1, 2, 3, 9.
        drive(4'b1110, 7'b1001111, 8);
        check("scan0_pulses", 32'(pulses), 32'd1);
        check("scan0_idx", 32'(last_idx), 32'd0);
        drive(4'b1101, 7'b0010010, 8);
        check("scan1_pulses", 32'(pulses), 32'd1);
        check("scan1_idx", 32'(last_idx), 32'd1);
        drive(4'b1011, 7'b0000110, 8);
        check("scan2_pulses", 32'(pulses), 32'd1);
        check("scan2_idx", 32'(last_idx), 32'd2);
        drive(4'b0111, 7'b0000100, 8);
        check("scan3_pulses", 32'(pulses), 32'd1);
        check("scan3_idx", 32'(last_idx), 32'd3);
        check("scan_digits", 32'(bus.digits),
              32'({5'd9, 5'd3, 5'd2, 5'd1}));
        check("scan_valid", 32'(bus.digit_valid), 32'hF);

        // Latency: stable from edge k, update at edge k+6.
        drive(4'b1110, 7'b0000110, 10);
        check("lat_first", 32'(first_at), 32'd6);
        check("lat_pulses", 32'(pulses), 32'd1);
        check("lat_d0", 32'(bus.digits[4:0]), 32'd3);

        // Two-cycle glitch to 8 mid-hold.
        drive(4'b1110, 7'b0000110, 3);
        tot = pulses;
        drive(4'b1110, 7'b0000000, 2);
        tot += pulses;
        drive(4'b1110, 7'b0000110, 10);
        tot += pulses;
        check("glitch_pulses", 32'(tot), 32'd0);
        check("glitch_d0", 32'(bus.digits[4:0]), 32'd3);

        // Rescan same value, then change to 5.
        drive(4'b1111, 7'b1111111, 8);
        tot = pulses;
        drive(4'b1110, 7'b0000110, 8);
        tot += pulses;
        check("same_pulses", 32'(tot), 32'd0);
        drive(4'b1110, 7'b0100100, 8);
        check("chg_pulses", 32'(pulses), 32'd1);
        check("chg_idx", 32'(last_idx), 32'd0);
        check("chg_d0", 32'(bus.digits[4:0]), 32'd5);

        // Shared pattern and illegal pattern on digit 2.
        drive(4'b1011, 7'b1111110, 8);
        check("stable_d2", 32'(bus.digits[14:10]), 32'd10);
        check("stable_err", 32'(bus.err), 32'd0);
        drive(4'b1011, 7'b1010101, 8);
        check("ill_d2", 32'(bus.digits[14:10]), 32'd31);
        check("ill_err", 32'(bus.err), 32'd1);
        clr_pulse();
        check("clr_err", 32'(bus.err), 32'd0);

        // Clear and new illegal commit in the same cycle.
        drive(4'b1011, 7'b1010100, 6);
        check("pre_set_err", 32'(bus.err), 32'd0);
        clr_pulse();
        check("setwins_err", 32'(bus.err), 32'd1);
        clr_pulse();
        check("clr2_err", 32'(bus.err), 32'd0);

        // Two active anodes.
        drive(4'b1100, 7'b0000000, 8);
        check("multi_err", 32'(bus.err), 32'd1);
        check("multi_pulses", 32'(pulses), 32'd0);
        check("multi_digits", 32'(bus.digits),
              32'({5'd9, 5'd31, 5'd2, 5'd5}));
        clr_pulse();
        drive(4'b1111, 7'b0000000, 8);
        check("blank_err", 32'(bus.err), 32'd0);
        check("blank_pulses", 32'(pulses), 32'd0);
        check("blank_digits", 32'(bus.digits),
              32'({5'd9, 5'd31, 5'd2, 5'd5}));

        // Reset during acquire.
        drive(4'b1110, 7'b0001111, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_digits", 32'(bus.digits), 32'h0);
        check("mid_rst_valid", 32'(bus.digit_valid), 32'h0);
        check("mid_rst_update", 32'(bus.update), 32'h0);
        check("mid_rst_err", 32'(bus.err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1110, 7'b0001111, 10);
        check("post_rst_first", 32'(first_at), 32'd6);
        check("post_rst_d0", 32'(bus.digits[4:0]), 32'd7);
        check("post_rst_valid", 32'(bus.digit_valid), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
